// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: ALU operation encodings and the multiplier
// sequencer state, visible to both RTL and benches.
package cpu_types_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_SLT = 4'h8
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } multseq_state_t;

endpackage

// File: rtl/alu_if.sv
// Signal bundle between an ALU and whatever initiator drives its operands.
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t            aluop;
  logic [XLEN-1:0]   porta;
  logic [XLEN-1:0]   portb;
  logic [XLEN-1:0]   outport;
  logic              zero;
  logic              negative;
  logic              overflow;

  modport alu (input aluop, porta, portb, output outport, zero, negative, overflow);
  modport initiator (output aluop, porta, portb, input outport, zero, negative, overflow);
endinterface

// File: rtl/alu.sv
// Combinational datapath ALU; shifts move portb by porta[4:0].
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu bus
);

  logic [XLEN-1:0] w_res;
  logic            w_ovf;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.aluop)
      ALU_ADD: begin
        w_res = bus.porta + bus.portb;
        w_ovf = (bus.porta[XLEN-1] == bus.portb[XLEN-1]) && (w_res[XLEN-1] != bus.porta[XLEN-1]);
      end
      ALU_SUB: begin
        w_res = bus.porta - bus.portb;
        w_ovf = (bus.porta[XLEN-1] != bus.portb[XLEN-1]) && (w_res[XLEN-1] != bus.porta[XLEN-1]);
      end
      ALU_AND: w_res = bus.porta & bus.portb;
      ALU_OR:  w_res = bus.porta | bus.portb;
      ALU_XOR: w_res = bus.porta ^ bus.portb;
      ALU_SLL: w_res = bus.portb << bus.porta[4:0];
      ALU_SRL: w_res = bus.portb >> bus.porta[4:0];
      ALU_SRA: w_res = $unsigned($signed(bus.portb) >>> bus.porta[4:0]);
      ALU_SLT: w_res = {{(XLEN-1){1'b0}}, ($signed(bus.porta) < $signed(bus.portb))};
      default: w_res = '0;
    endcase
  end

  assign bus.outport  = w_res;
  assign bus.zero     = (w_res == '0);
  assign bus.negative = w_res[XLEN-1];
  assign bus.overflow = w_ovf;

endmodule

// File: rtl/alu_mult_seq.sv
// Shift-add multiplier that borrows the datapath ALU for every add and shift;
// returns the low word of an unsigned 32x32 product via start/busy/done.
module alu_mult_seq
  import cpu_types_pkg::*;
#(
  parameter int EARLY_EXIT = 1,
  parameter int ITERS      = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output aluop_t      aluop,
  output logic [31:0] porta,
  output logic [31:0] portb,
  input  logic [31:0] outport
);

  localparam int CW = $clog2(ITERS + 1);

  multseq_state_t r_state;
  logic [31:0]    r_acc;
  logic [31:0]    r_mcand;
  logic [31:0]    r_mplier;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_product;
  logic           r_busy;
  logic           r_done;

  // DONE accepts a new start exactly like IDLE, so back-to-back ops lose no cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_count  <= '0;
            if (EARLY_EXIT != 0 && b == '0) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_product <= '0;
            end else if (b[0]) begin
              r_state <= ADD;
              r_busy  <= 1'b1;
            end else begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        ADD: begin
          r_acc   <= outport;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_mcand  <= outport;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == CW'(ITERS - 1) || (EARLY_EXIT != 0 && (r_mplier >> 1) == '0)) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_product <= r_acc;
          end else if (r_mplier[1]) begin
            r_state <= ADD;
          end else begin
            r_state <= SHIFT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Idle drives a harmless ADD of zeros so the shared ALU never sees stale operands.
  always_comb begin
    aluop = ALU_ADD;
    porta = '0;
    portb = '0;
    case (r_state)
      ADD: begin
        porta = r_acc;
        portb = r_mcand;
      end
      SHIFT: begin
        aluop = ALU_SLL;
        porta = 32'd1;
        portb = r_mcand;
      end
      default: ;
    endcase
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
